// File: rtl/ps2_rx_frame_pkg.sv
// rtl/ps2_rx_frame_pkg.sv - shared PS/2 receive definitions: frame FSM states, data width, parity helper
`timescale 1ns/1ps
package ps2_rx_frame_pkg;

  localparam int PS2_DATA_BITS = 8;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DATA   = 2'd1,
    ST_PARITY = 2'd2,
    ST_STOP   = 2'd3
  } ps2_state_t;

  // Odd parity: data plus parity bit must hold an odd number of ones.
  function automatic logic odd_parity_ok(input logic [PS2_DATA_BITS-1:0] d, input logic p);
    return ^{d, p};
  endfunction

endpackage

// File: rtl/ps2_clk_filter.sv
// rtl/ps2_clk_filter.sv - PS/2 clock synchroniser and deglitcher with a falling-edge pulse
`timescale 1ns/1ps
module ps2_clk_filter #(
  parameter int FILTER_LEN = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic ps2_clk,
  output logic fall
);

  localparam logic [7:0] CNT_LAST = 8'(FILTER_LEN - 1);

  logic [1:0] sync;
  logic       clk_filt;
  logic [7:0] cnt;

  // Filtered clock only moves after FILTER_LEN consecutive disagreeing samples.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync     <= 2'b11;
      clk_filt <= 1'b1;
      cnt      <= 8'd0;
      fall     <= 1'b0;
    end else begin
      sync <= {sync[0], ps2_clk};
      fall <= 1'b0;
      if (sync[1] == clk_filt) begin
        cnt <= 8'd0;
      end else if (cnt == CNT_LAST) begin
        clk_filt <= sync[1];
        cnt      <= 8'd0;
        fall     <= clk_filt;
      end else begin
        cnt <= cnt + 8'd1;
      end
    end
  end

endmodule

// File: rtl/ps2_rx_frame.sv
// rtl/ps2_rx_frame.sv - PS/2 device-to-host frame receiver emitting one byte per good frame
`timescale 1ns/1ps
module ps2_rx_frame
  import ps2_rx_frame_pkg::*;
#(
  parameter int FILTER_LEN  = 8,
  parameter int BIT_TIMEOUT = 10000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] byte_data,
  output logic       byte_valid,
  output logic       frame_err,
  output logic       busy
);

  localparam int TW = $clog2(BIT_TIMEOUT);
  localparam int CW = $clog2(PS2_DATA_BITS);
  localparam logic [TW-1:0] T_LAST   = TW'(BIT_TIMEOUT - 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(PS2_DATA_BITS - 1);

  ps2_state_t state, state_nxt;
  logic [1:0] data_sync;
  logic       d;
  logic       fall;
  logic       timeout;
  logic [PS2_DATA_BITS-1:0] sr, sr_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic       par, par_nxt;
  logic [TW-1:0] tcnt;
  logic       valid_nxt, err_nxt;

  ps2_clk_filter #(.FILTER_LEN(FILTER_LEN)) u_clk_filter (
    .clk     (clk),
    .rst     (rst),
    .ps2_clk (ps2_clk),
    .fall    (fall)
  );

  assign d       = data_sync[1];
  assign busy    = (state != ST_IDLE);
  assign timeout = (state != ST_IDLE) && (tcnt == T_LAST);

  // A timeout wins over a fall arriving in the same cycle.
  always_comb begin
    state_nxt = state;
    sr_nxt    = sr;
    cnt_nxt   = cnt;
    par_nxt   = par;
    valid_nxt = 1'b0;
    err_nxt   = 1'b0;
    if (timeout) begin
      state_nxt = ST_IDLE;
      err_nxt   = 1'b1;
    end else if (fall) begin
      case (state)
        ST_IDLE: begin
          if (!d) begin
            state_nxt = ST_DATA;
            cnt_nxt   = '0;
          end
        end
        ST_DATA: begin
          sr_nxt = {d, sr[PS2_DATA_BITS-1:1]};
          if (cnt == CNT_LAST) state_nxt = ST_PARITY;
          else                 cnt_nxt   = cnt + 1'b1;
        end
        ST_PARITY: begin
          par_nxt   = d;
          state_nxt = ST_STOP;
        end
        ST_STOP: begin
          if (d && odd_parity_ok(sr, par)) valid_nxt = 1'b1;
          else                             err_nxt   = 1'b1;
          state_nxt = ST_IDLE;
        end
        default: state_nxt = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      data_sync  <= 2'b11;
      sr         <= '0;
      cnt        <= '0;
      par        <= 1'b0;
      tcnt       <= '0;
      byte_data  <= 8'd0;
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      state      <= state_nxt;
      data_sync  <= {data_sync[0], ps2_data};
      sr         <= sr_nxt;
      cnt        <= cnt_nxt;
      par        <= par_nxt;
      byte_valid <= valid_nxt;
      frame_err  <= err_nxt;
      if (valid_nxt) byte_data <= sr;
      if (state == ST_IDLE || fall || timeout) tcnt <= '0;
      else                                     tcnt <= tcnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_ps2_rx_frame.sv
// tb/tb_ps2_rx_frame.sv - directed self-checking bench for ps2_rx_frame
`timescale 1ns/1ps
module tb_ps2_rx_frame;

  localparam int HALF = 40;
  localparam int BT   = 10000;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic [7:0] byte_data;
  logic       byte_valid;
  logic       frame_err;
  logic       busy;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int vcyc = 0;
  int err_cycles = 0;
  int both_cycles = 0;
  logic [7:0] vq[$];

  ps2_rx_frame #(.FILTER_LEN(8), .BIT_TIMEOUT(BT)) dut (
    .clk        (clk),
    .rst        (rst),
    .ps2_clk    (ps2_clk),
    .ps2_data   (ps2_data),
    .byte_data  (byte_data),
    .byte_valid (byte_valid),
    .frame_err  (frame_err),
    .busy       (busy)
  );

  always #10 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (byte_valid) begin
      vq.push_back(byte_data);
      vcyc = cyc;
    end
    if (frame_err) err_cycles++;
    if (byte_valid && frame_err) both_cycles++;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_bit(input logic b, input bit glitch, output int fall_cyc);
    ps2_data = b;
    if (glitch) begin
      wait_cyc(10);
      ps2_clk = 1'b0;
      wait_cyc(5);
      ps2_clk = 1'b1;
      wait_cyc(HALF - 15);
    end else begin
      wait_cyc(HALF);
    end
    ps2_clk  = 1'b0;
    fall_cyc = cyc;
    wait_cyc(HALF);
    ps2_clk = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic flip_par, input logic stop,
                            input bit glitch, output int stop_fall);
    int fc;
    logic p;
    p = (~^b) ^ flip_par;
    send_bit(1'b0, glitch, fc);
    for (int i = 0; i < 8; i++) send_bit(b[i], glitch, fc);
    send_bit(p, glitch, fc);
    send_bit(stop, glitch, stop_fall);
    ps2_data = 1'b1;
  endtask

  task automatic clear_mon();
    vq.delete();
    err_cycles  = 0;
    both_cycles = 0;
  endtask

  task automatic test_reset();
    wait_cyc(5);
    rst = 1'b0;
    wait_cyc(3);
    checks++; if (byte_data !== 8'h00) begin errors++; $display("FAIL reset_byte_data got %h exp 00", byte_data); end
    checks++; if (byte_valid !== 1'b0) begin errors++; $display("FAIL reset_byte_valid got %b exp 0", byte_valid); end
    checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL reset_frame_err got %b exp 0", frame_err); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
  endtask

  task automatic test_good();
    int sf;
    int lat;
    clear_mon();
    send_frame(8'h1A, 1'b0, 1'b1, 1'b0, sf);
    wait_cyc(20);
    lat = vcyc - sf;
    checks++; if (vq.size() !== 1) begin errors++; $display("FAIL good_count got %0d exp 1", vq.size()); end
    else begin
      checks++; if (vq[0] !== 8'h1A) begin errors++; $display("FAIL good_value got %h exp 1a", vq[0]); end
    end
    checks++; if (byte_data !== 8'h1A) begin errors++; $display("FAIL good_byte_data got %h exp 1a", byte_data); end
    checks++; if (err_cycles !== 0) begin errors++; $display("FAIL good_frame_err got %0d exp 0", err_cycles); end
    checks++; if (lat < 9 || lat > 13) begin errors++; $display("FAIL good_latency got %0d exp 9..13", lat); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL good_busy_after got %b exp 0", busy); end
  endtask

  task automatic test_parity();
    int sf;
    clear_mon();
    send_frame(8'h75, 1'b1, 1'b1, 1'b0, sf);
    wait_cyc(20);
    checks++; if (err_cycles !== 1) begin errors++; $display("FAIL parity_err_cycles got %0d exp 1", err_cycles); end
    checks++; if (vq.size() !== 0) begin errors++; $display("FAIL parity_valid got %0d exp 0", vq.size()); end
    checks++; if (byte_data !== 8'h1A) begin errors++; $display("FAIL parity_byte_kept got %h exp 1a", byte_data); end
    clear_mon();
    send_frame(8'h3C, 1'b0, 1'b0, 1'b0, sf);
    wait_cyc(20);
    checks++; if (err_cycles !== 1) begin errors++; $display("FAIL stop_err_cycles got %0d exp 1", err_cycles); end
    checks++; if (vq.size() !== 0) begin errors++; $display("FAIL stop_valid got %0d exp 0", vq.size()); end
    checks++; if (byte_data !== 8'h1A) begin errors++; $display("FAIL stop_byte_kept got %h exp 1a", byte_data); end
  endtask

  task automatic test_reset_midframe();
    int fc;
    clear_mon();
    send_bit(1'b0, 1'b0, fc);
    for (int i = 0; i < 3; i++) send_bit(1'b1, 1'b0, fc);
    ps2_data = 1'b0;
    wait_cyc(HALF);
    ps2_clk = 1'b0;
    wait_cyc(20);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL midframe_busy got %b exp 1", busy); end
    rst = 1'b1;
    #1;
    checks++; if ({byte_data, byte_valid, frame_err, busy} !== 11'b0) begin
      errors++; $display("FAIL midframe_reset_outputs got %h/%b/%b/%b exp 00/0/0/0", byte_data, byte_valid, frame_err, busy);
    end
    wait_cyc(4);
    ps2_clk  = 1'b1;
    ps2_data = 1'b1;
    wait_cyc(4);
    rst = 1'b0;
    wait_cyc(30);
    checks++; if (vq.size() !== 0 || err_cycles !== 0) begin
      errors++; $display("FAIL midframe_pulses got valid %0d err %0d exp 0 0", vq.size(), err_cycles);
    end
  endtask

  task automatic test_glitch();
    int sf;
    clear_mon();
    send_frame(8'hF0, 1'b0, 1'b1, 1'b1, sf);
    wait_cyc(20);
    checks++; if (vq.size() !== 1) begin errors++; $display("FAIL glitch_count got %0d exp 1", vq.size()); end
    else begin
      checks++; if (vq[0] !== 8'hF0) begin errors++; $display("FAIL glitch_value got %h exp f0", vq[0]); end
    end
    checks++; if (err_cycles !== 0) begin errors++; $display("FAIL glitch_frame_err got %0d exp 0", err_cycles); end
  endtask

  task automatic test_timeout();
    int fc;
    int sf;
    clear_mon();
    send_bit(1'b0, 1'b0, fc);
    for (int i = 0; i < 4; i++) send_bit(i[0], 1'b0, fc);
    wait_cyc(5);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL timeout_busy_before got %b exp 1", busy); end
    wait_cyc(BT + 200);
    checks++; if (err_cycles !== 1) begin errors++; $display("FAIL timeout_err_cycles got %0d exp 1", err_cycles); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL timeout_busy_after got %b exp 0", busy); end
    checks++; if (vq.size() !== 0) begin errors++; $display("FAIL timeout_valid got %0d exp 0", vq.size()); end
    checks++; if (byte_data !== 8'hF0) begin errors++; $display("FAIL timeout_byte_kept got %h exp f0", byte_data); end
    clear_mon();
    send_frame(8'hE0, 1'b0, 1'b1, 1'b0, sf);
    wait_cyc(20);
    checks++; if (vq.size() !== 1 || byte_data !== 8'hE0) begin
      errors++; $display("FAIL timeout_recover got count %0d data %h exp 1 e0", vq.size(), byte_data);
    end
  endtask

  task automatic test_back_to_back();
    int sf;
    logic [7:0] exp_b[3];
    exp_b[0] = 8'hE0;
    exp_b[1] = 8'hF0;
    exp_b[2] = 8'h6B;
    clear_mon();
    for (int i = 0; i < 3; i++) send_frame(exp_b[i], 1'b0, 1'b1, 1'b0, sf);
    wait_cyc(20);
    checks++; if (vq.size() !== 3) begin errors++; $display("FAIL b2b_count got %0d exp 3", vq.size()); end
    else begin
      for (int i = 0; i < 3; i++) begin
        checks++; if (vq[i] !== exp_b[i]) begin errors++; $display("FAIL b2b_value%0d got %h exp %h", i, vq[i], exp_b[i]); end
      end
    end
    checks++; if (err_cycles !== 0) begin errors++; $display("FAIL b2b_frame_err got %0d exp 0", err_cycles); end
    checks++; if (both_cycles !== 0) begin errors++; $display("FAIL b2b_overlap got %0d exp 0", both_cycles); end
  endtask

  initial begin
    test_reset();
    test_good();
    test_parity();
    test_reset_midframe();
    test_glitch();
    test_timeout();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
